spinn_pkt_arbiter: RTL and testbench
====================================

Name: spinn_pkt_arbiter

Overview:
- Shares the single SpiNNaker packet input of the link driver between NUM_REQ packet sources, such as several DVS-to-SpiNNaker receiver/mappers.
- Each source offers 40-bit packets on a vld/rdy handshake. The block picks one source round-robin, holds the packet in a one-entry output register and presents it to the driver.
- If the driver stalls too long, the block enters a dump mode. In dump mode it accepts and discards source packets and counts them per source, so upstream logic never deadlocks.

Parameters:
- NUM_REQ, 4, number of requesting packet sources (2..8).
- PKT_W, 40, packet width (39-bit packet plus parity; carried verbatim, never modified).
- DUMP_CYCLES, 128, number of stalled cycles tolerated in SEND before dumping.
- CNT_W, 16, width of each per-source drop counter.

Ports:
- clk_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- enable  in  1  when low, no new grants are issued; SEND and DUMP continue.
- req_pkt  in  NUM_REQ*PKT_W  source i packet at bits [i*PKT_W +: PKT_W].
- req_vld  in  NUM_REQ  source i offers a packet.
- req_rdy  out  NUM_REQ  source i packet consumed on this edge (combinational).
- out_pkt  out  PKT_W  packet to the link driver.
- out_vld  out  1  out_pkt valid.
- out_rdy  in  1  driver accepts out_pkt on this edge.
- grant_idx  out  $clog2(NUM_REQ)  source index of the packet currently in out_pkt.
- dump  out  1  high while in DUMP state.
- clr_cnt  in  1  synchronous clear of all drop counters.
- drop_cnt  out  NUM_REQ*CNT_W  per-source saturating count of discarded packets; source i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset values: state=IDLE, out_vld=0, out_pkt=0, grant_idx=0, dump=0, all drop_cnt=0, round-robin pointer last=NUM_REQ-1 (source 0 has first priority). req_rdy is forced 0 while reset is high.
- A transfer occurs on an edge where req_vld[i] and req_rdy[i] are both high, or where out_vld and out_rdy are both high.
- State IDLE:
  - If enable and any req_vld, winner g = first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - req_rdy[g]=1 (only that bit) in the same cycle.
  - On that edge: out_pkt<=req_pkt[g], grant_idx<=g, last<=g, timeout ctr<=DUMP_CYCLES, state->SEND.
  - Otherwise req_rdy=0 and the block stays in IDLE.
- State SEND:
  - out_vld=1 and req_rdy=0.
  - If out_rdy: the packet transfers; state->IDLE. out_vld is 0 on the next cycle, so throughput is 1 packet per 2 cycles.
  - Else if ctr==0: state->DUMP; the held packet is discarded and drop_cnt[grant_idx] increments.
  - Else ctr<=ctr-1.
  - Maximum out_vld-high duration without out_rdy: DUMP_CYCLES+1 cycles.
- State DUMP:
  - dump=1, out_vld=0.
  - req_rdy[i]=req_vld[i] & ~out_rdy for all i; each discarded packet increments its drop_cnt[i] on that edge.
  - out_rdy=1 -> state->IDLE, and no packets are discarded in that cycle.
  - enable has no effect in DUMP.
- dump and out_vld are registered and reflect the current state (no combinational path from out_rdy).
- Drop counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt has priority over a simultaneous increment (the counter ends at 0).
  - Several counters may increment in the same cycle.
- enable deasserted in SEND: the held packet still completes or times out normally.
- Reset mid-operation: return to the reset values on the next edge. A packet held in out_pkt is lost and not counted.
- Round-robin fairness: with all sources continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...

Test Plan:
- Reset, then req_vld=4'b0001 with req_pkt0=40'h0005_8000_00, out_rdy=1 -> req_rdy=0001 for 1 cycle; out_vld high exactly 1 cycle later with out_pkt=40'h0005_8000_00, grant_idx=0; back to IDLE.
- req_vld=4'b1111 held, out_rdy=1 -> grant_idx sequence 0,1,2,3,0 over 5 packets (10 cycles); exactly one req_rdy bit per grant.
- Single packet from source 2, out_rdy=0 held -> out_vld high 129 cycles, then dump=1, out_vld=0, drop_cnt2=1.
- While dumping, req_vld=4'b0011 for 3 cycles -> drop_cnt0=3, drop_cnt1=3. Then out_rdy=1 -> dump=0 next cycle, no drop in that cycle.
- Preload drop_cnt1 to 2^16-1 via dumping (or force) -> a further discard holds 16'hFFFF. clr_cnt together with an increment -> 0.
- enable=0 with req_vld=4'b0100 -> req_rdy stays 0000. Then reset asserted while in SEND -> out_vld=0, state IDLE, drop counters unchanged.

Source files
------------

// File: rtl/spinn_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spinn_pkt_arbiter
// Purpose  : Round-robin sharing of the SpiNNaker link-driver packet input
//            between NUM_REQ sources, with a stall-triggered dump mode that
//            discards and counts packets so upstream never deadlocks.
// Revision : 1.0 - initial release
// ============================================================================
module spinn_pkt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PKT_W       = 40,
    parameter int DUMP_CYCLES = 128,
    parameter int CNT_W       = 16
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ*PKT_W-1:0]   req_pkt,
    input  logic [NUM_REQ-1:0]         req_vld,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic [PKT_W-1:0]           out_pkt,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       dump,
    input  logic                       clr_cnt,
    output logic [NUM_REQ*CNT_W-1:0]   drop_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CTR_W = $clog2(DUMP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [NUM_REQ-1:0] drop_inc;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;

    // Scan last+1, last+2, ... (mod NUM_REQ); the extra bit holds the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && req_vld[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ctr_d    = ctr_q;
        pkt_d    = pkt_q;
        req_rdy  = '0;
        drop_inc = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && win_found) begin
                    req_rdy[win_idx] = 1'b1;
                    pkt_d            = req_pkt[int'(win_idx)*PKT_W +: PKT_W];
                    grant_d          = win_idx;
                    last_d           = win_idx;
                    ctr_d            = CTR_W'(DUMP_CYCLES);
                    state_d          = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_rdy) begin
                    state_d = ST_IDLE;
                end else if (ctr_q == '0) begin
                    state_d           = ST_DUMP;
                    drop_inc[grant_q] = 1'b1;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            ST_DUMP: begin
                // Releasing the dump on out_rdy takes priority over discarding.
                if (out_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    req_rdy  = req_vld;
                    drop_inc = req_vld;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            req_rdy = '0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            ctr_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ctr_q   <= ctr_d;
            pkt_q   <= pkt_d;
        end
    end

    assign out_vld   = (state_q == ST_SEND);
    assign dump      = (state_q == ST_DUMP);
    assign out_pkt   = pkt_q;
    assign grant_idx = grant_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_cnt) begin
                cnt_d = '0;
            end else if (drop_inc[i] && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_50) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign drop_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spinn_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spinn_pkt_arbiter
// Purpose  : Directed and randomized checks of spinn_pkt_arbiter against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spinn_pkt_arbiter;

    localparam int N    = 4;
    localparam int W    = 40;
    localparam int DC   = 128;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N*W-1:0] req_pkt;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   out_pkt;
    logic           out_vld;
    logic           out_rdy;
    logic [1:0]     grant_idx;
    logic           dump;
    logic           clr_cnt;
    logic [N*CW-1:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode 0 = waiting, 1 = offering packet, 2 = discarding
    int           m_mode;
    int           m_last;
    int           m_left;
    int           m_gidx;
    logic [W-1:0] m_pkt;
    int           m_drop [N];

    spinn_pkt_arbiter #(
        .NUM_REQ(N), .PKT_W(W), .DUMP_CYCLES(DC), .CNT_W(CW)
    ) dut (
        .clk_50(clk), .reset(reset), .enable(enable),
        .req_pkt(req_pkt), .req_vld(req_vld), .req_rdy(req_rdy),
        .out_pkt(out_pkt), .out_vld(out_vld), .out_rdy(out_rdy),
        .grant_idx(grant_idx), .dump(dump),
        .clr_cnt(clr_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        r = '0;
        if (reset) return r;
        if (m_mode == 0 && enable) begin
            for (int k = 1; k <= N; k++) begin
                if (req_vld[(m_last + k) % N]) begin
                    r[(m_last + k) % N] = 1'b1;
                    return r;
                end
            end
        end else if (m_mode == 2 && !out_rdy) begin
            r = req_vld;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return drop_cnt[i*CW +: CW];
    endfunction

    task automatic model_step();
        logic [N-1:0] r;
        int inc [N];
        r = exp_rdy();
        for (int i = 0; i < N; i++) inc[i] = 0;
        if (reset) begin
            m_mode = 0; m_last = N - 1; m_left = 0; m_gidx = 0; m_pkt = '0;
            for (int i = 0; i < N; i++) m_drop[i] = 0;
            return;
        end
        if (m_mode == 0) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    m_pkt = req_pkt[i*W +: W]; m_gidx = i; m_last = i;
                    m_left = DC; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (out_rdy) m_mode = 0;
            else if (m_left == 0) begin m_mode = 2; inc[m_gidx] = 1; end
            else m_left--;
        end else begin
            if (out_rdy) m_mode = 0;
            else for (int i = 0; i < N; i++) inc[i] = int'(req_vld[i]);
        end
        for (int i = 0; i < N; i++) begin
            if (clr_cnt) m_drop[i] = 0;
            else if (inc[i] != 0 && m_drop[i] < CMAX) m_drop[i]++;
        end
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_vld = '0; out_rdy = 1'b0; clr_cnt = 1'b0; enable = 1'b1;
        advance();
        advance();
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_pkt();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_vld = 4'b1111; enable = 1'b1; out_rdy = 1'b1; clr_cnt = 1'b0;
        #1;
        n_cmp++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy); end
        advance(); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
        n_cmp++; if (dump !== 1'b0) begin n_fail++; $display("FAIL reset_dump got=%b exp=0", dump); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        n_cmp++; if (out_pkt !== '0) begin n_fail++; $display("FAIL reset_pkt got=%h exp=0", out_pkt); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
        reset = 1'b0; req_vld = '0; out_rdy = 1'b0;
        advance();
    endtask

    task automatic test_single();
        do_reset();
        req_vld = 4'b0001; req_pkt = '0; req_pkt[0 +: W] = 40'h0005800000; out_rdy = 1'b1;
        #1;
        n_cmp++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_rdy got=%b exp=0001", req_rdy); end
        n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld0 got=%b exp=0", out_vld); end
        advance(); req_vld = '0; #1;
        n_cmp++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld1 got=%b exp=1", out_vld); end
        n_cmp++; if (out_pkt !== 40'h0005800000) begin n_fail++; $display("FAIL single_pkt got=%h exp=0005800000", out_pkt); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_grant got=%0d exp=0", grant_idx); end
        n_cmp++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL single_rdy_send got=%b exp=0000", req_rdy); end
        advance(); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld2 got=%b exp=0", out_vld); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] sent;
        int g;
        do_reset();
        req_vld = 4'b1111; out_rdy = 1'b1; sent = '0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) req_pkt[i*W +: W] = rnd_pkt();
            g = (c / 2) % N;
            #1;
            if (c % 2 == 0) begin
                sent = req_pkt[g*W +: W];
                n_cmp++; if (req_rdy !== 4'(1 << g)) begin n_fail++; $display("FAIL rr_rdy cyc=%0d got=%b exp_src=%0d", c, req_rdy, g); end
            end else begin
                n_cmp++; if (grant_idx !== 2'(g) || out_vld !== 1'b1) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%0d/%b exp=%0d/1", c, grant_idx, out_vld, g); end
                n_cmp++; if (out_pkt !== sent) begin n_fail++; $display("FAIL rr_pkt cyc=%0d got=%h exp=%h", c, out_pkt, sent); end
            end
            advance();
        end
        req_vld = '0;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req_vld = 4'b0100; req_pkt[2*W +: W] = rnd_pkt(); out_rdy = 1'b0;
        #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL to_rdy got=%b exp=0100", req_rdy); end
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            advance(); req_vld = '0; #1;
            if (!out_vld) break;
            cnt++;
        end
        n_cmp++; if (cnt != DC + 1) begin n_fail++; $display("FAIL to_len got=%0d exp=%0d", cnt, DC + 1); end
        n_cmp++; if (dump !== 1'b1) begin n_fail++; $display("FAIL to_dump got=%b exp=1", dump); end
        n_cmp++; if (cnt_of(2) !== 16'd1) begin n_fail++; $display("FAIL to_drop2 got=%0d exp=1", cnt_of(2)); end
    endtask

    task automatic test_dump_drops();
        for (int c = 0; c < 3; c++) begin
            req_vld = 4'b0011; #1;
            n_cmp++; if (req_rdy !== 4'b0011) begin n_fail++; $display("FAIL dd_rdy cyc=%0d got=%b exp=0011", c, req_rdy); end
            advance();
        end
        out_rdy = 1'b1; #1;
        n_cmp++; if (cnt_of(0) !== 16'd3 || cnt_of(1) !== 16'd3) begin n_fail++; $display("FAIL dd_cnt got=%0d,%0d exp=3,3", cnt_of(0), cnt_of(1)); end
        n_cmp++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL dd_exit_rdy got=%b exp=0000", req_rdy); end
        advance(); req_vld = '0; out_rdy = 1'b0; #1;
        n_cmp++; if (dump !== 1'b0) begin n_fail++; $display("FAIL dd_exit got=%b exp=0", dump); end
        n_cmp++; if (cnt_of(0) !== 16'd3 || cnt_of(1) !== 16'd3) begin n_fail++; $display("FAIL dd_nodrop got=%0d,%0d exp=3,3", cnt_of(0), cnt_of(1)); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        req_vld = 4'b0001; out_rdy = 1'b0;
        advance(); req_vld = '0;
        for (int k = 0; k < 200 && !dump; k++) advance();
        #1;
        n_cmp++; if (dump !== 1'b1 || cnt_of(0) !== 16'd1) begin n_fail++; $display("FAIL sat_enter got=%b/%0d exp=1/1", dump, cnt_of(0)); end
        req_vld = 4'b0010;
        for (int k = 0; k < CMAX; k++) advance();
        #1;
        n_cmp++; if (cnt_of(1) !== 16'hFFFF) begin n_fail++; $display("FAIL sat_fill got=%h exp=ffff", cnt_of(1)); end
        advance(); #1;
        n_cmp++; if (cnt_of(1) !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", cnt_of(1)); end
        clr_cnt = 1'b1;
        advance(); clr_cnt = 1'b0; req_vld = '0; #1;
        n_cmp++; if (cnt_of(1) !== 16'd0 || cnt_of(0) !== 16'd0) begin n_fail++; $display("FAIL sat_clr got=%h,%h exp=0,0", cnt_of(1), cnt_of(0)); end
        out_rdy = 1'b1;
        advance(); out_rdy = 1'b0;
    endtask

    task automatic test_enable_reset();
        do_reset();
        enable = 1'b0; req_vld = 4'b0100; req_pkt[2*W +: W] = rnd_pkt();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_rdy !== 4'b0000 || out_vld !== 1'b0) begin n_fail++; $display("FAIL en_hold cyc=%0d got=%b/%b exp=0000/0", c, req_rdy, out_vld); end
            advance();
        end
        enable = 1'b1; #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL en_grant got=%b exp=0100", req_rdy); end
        advance(); enable = 1'b0; req_vld = '0; #1;
        n_cmp++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL en_send got=%b exp=1", out_vld); end
        advance(); #1;
        n_cmp++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL en_send_hold got=%b exp=1", out_vld); end
        reset = 1'b1;
        advance(); reset = 1'b0; enable = 1'b1; #1;
        n_cmp++; if (out_vld !== 1'b0 || dump !== 1'b0) begin n_fail++; $display("FAIL rst_mid got=%b/%b exp=0/0", out_vld, dump); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL rst_mid_drop got=%h exp=0", drop_cnt); end
        advance(); #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_idle got=%b exp=0", out_vld); end
    endtask

    task automatic test_random();
        do_reset();
        for (int ph = 0; ph < 9; ph++) begin
            int pct;
            pct = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 10 : 60);
            for (int c = 0; c < 300; c++) begin
                req_vld = 4'($urandom);
                for (int i = 0; i < N; i++) req_pkt[i*W +: W] = rnd_pkt();
                out_rdy = ($urandom_range(99) < pct);
                enable  = ($urandom_range(9) != 0);
                clr_cnt = ($urandom_range(63) == 0);
                #1;
                n_cmp++; if (req_rdy !== exp_rdy()) begin n_fail++; $display("FAIL rnd_rdy ph=%0d c=%0d got=%b exp=%b", ph, c, req_rdy, exp_rdy()); end
                n_cmp++; if (out_vld !== (m_mode == 1) || dump !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_mode ph=%0d c=%0d got=%b/%b exp_mode=%0d", ph, c, out_vld, dump, m_mode); end
                if (m_mode == 1) begin
                    n_cmp++; if (out_pkt !== m_pkt || grant_idx !== 2'(m_gidx)) begin n_fail++; $display("FAIL rnd_out ph=%0d c=%0d got=%h/%0d exp=%h/%0d", ph, c, out_pkt, grant_idx, m_pkt, m_gidx); end
                end
                for (int i = 0; i < N; i++) begin
                    n_cmp++; if (cnt_of(i) !== 16'(m_drop[i])) begin n_fail++; $display("FAIL rnd_drop%0d ph=%0d c=%0d got=%0d exp=%0d", i, ph, c, cnt_of(i), m_drop[i]); end
                end
                advance();
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req_pkt = '0; req_vld = '0; out_rdy = 1'b0; clr_cnt = 1'b0;
        m_mode = 0; m_last = N - 1; m_left = 0; m_gidx = 0; m_pkt = '0;
        for (int i = 0; i < N; i++) m_drop[i] = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_dump_drops();
        test_saturation();
        test_enable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
